// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receive front end.
// The raw clock and data lines are synchronized and the clock is debounced.
// Each 11-bit frame (start, 8 data LSB-first, odd parity, stop) is then
// deserialized. A good frame updates scan_code together with a one-cycle
// scan_done_tick. A bad or stalled frame gives a one-cycle frame_err instead.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,       // 2..16 equal samples to move fc
    parameter int TIMEOUT_CYCLES = 100000   // >= 2; idle limit inside a frame
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] scan_code,
    output logic       scan_done_tick,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    // frame_err is a registered pulse. It is set on the clock edge that ends
    // cycle fall+T-1, so it is high exactly T cycles after the last fall.
    // That cycle sees the counter at T-2.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        LOAD
    } state_t;

    // Input synchronizers and filter
    logic                  c_sync1, c_sync2;
    logic                  d_sync1, d_sync2;
    logic [FILTER_LEN-1:0] filt;
    logic                  fc, fc_q;
    logic                  fall;

    // Receiver state
    state_t        state, state_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [TW-1:0] to_cnt, to_cnt_next;
    logic [10:0]   frame, frame_next, frame_shift;
    logic [7:0]    code_next;
    logic          tick_next, err_next;

    // Two-flop synchronizers on both raw lines, idling high like the bus
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values, which is what makes the 2-flop chain
        // a chain rather than a single wire.
        if (reset) begin
            c_sync1 <= 1'b1;
            c_sync2 <= 1'b1;
            d_sync1 <= 1'b1;
            d_sync2 <= 1'b1;
        end else begin
            c_sync1 <= ps2c;
            c_sync2 <= c_sync1;
            d_sync1 <= ps2d;
            d_sync2 <= d_sync1;
        end
    end

    // Debounce: fc moves only after FILTER_LEN identical clock samples
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= '1;
            fc   <= 1'b1;
            fc_q <= 1'b1;
        end else begin
            filt <= {filt[FILTER_LEN-2:0], c_sync2};
            if (&filt)
                fc <= 1'b1;
            else if (~|filt)
                fc <= 1'b0;
            fc_q <= fc;
        end
    end

    // One-cycle strobe in the first cycle the filtered clock reads low
    assign fall = fc_q & ~fc;

    // New bit enters at the MSB so the start bit ends up at [0] after 11 shifts
    assign frame_shift = {d_sync2, frame[10:1]};

    // Frame check: odd parity over data+parity, stop bit high
    function automatic logic frame_good(input logic [10:0] f);
        return (^f[9:1]) & f[10];
    endfunction

    // Receiver state register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            to_cnt         <= '0;
            frame          <= '0;
            scan_code      <= '0;
            scan_done_tick <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            state          <= state_next;
            bit_cnt        <= bit_cnt_next;
            to_cnt         <= to_cnt_next;
            frame          <= frame_next;
            scan_code      <= code_next;
            scan_done_tick <= tick_next;
            frame_err      <= err_next;
        end
    end

    // Next-state logic. The frame verdict is taken on the stop-bit fall, so
    // the tick (or error) and the new scan_code are visible in the LOAD cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that forgets to assign one would otherwise infer a latch.
        state_next   = state;
        bit_cnt_next = bit_cnt;
        to_cnt_next  = to_cnt;
        frame_next   = frame;
        code_next    = scan_code;
        tick_next    = 1'b0;
        err_next     = 1'b0;

        unique case (state)
            IDLE: begin
                if (fall && !d_sync2 && rx_en) begin
                    frame_next   = frame_shift;
                    bit_cnt_next = 4'd10;
                    to_cnt_next  = '0;
                    state_next   = DATA;
                end
            end

            DATA: begin
                if (fall) begin
                    frame_next   = frame_shift;
                    bit_cnt_next = bit_cnt - 4'd1;
                    to_cnt_next  = '0;
                    if (bit_cnt == 4'd1) begin
                        state_next = LOAD;
                        if (frame_good(frame_shift)) begin
                            code_next = frame_shift[8:1];
                            tick_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_next    = 1'b1;
                    to_cnt_next = '0;
                    state_next  = IDLE;
                end else begin
                    to_cnt_next = to_cnt + TW'(1);
                end
            end

            LOAD: begin
                // A fall in this cycle is dropped; the next start bit is
                // accepted starting with the cycle after LOAD.
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed PS/2 frames with a queue-based scoreboard.
// The stimulus pushes each expected tick or error, with the exact cycle it is
// due, as it drives the frame. A separate monitor pops one entry per DUT event
// and compares it.
module tb_ps2_rx;

    localparam int FL    = 8;
    localparam int TO    = 2000;
    localparam int HALF  = 200;
    localparam int DFALL = FL + 3;   // raw ps2c low -> internal fall cycle

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       ps2c  = 1'b1;
    logic       ps2d  = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] scan_code;
    logic       scan_done_tick;
    logic       frame_err;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps2c           (ps2c),
        .ps2d           (ps2d),
        .rx_en          (rx_en),
        .scan_code      (scan_code),
        .scan_done_tick (scan_done_tick),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] last_code = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives bits [0..nbits-1] of {stop, par, data, start}. When want is set,
    // it queues the outcome at the final fall: tick or error for a full frame,
    // timeout error for a short one.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int nbits, input bit glitch, input bit want);
        logic [10:0] bits;
        int          fall_at;
        exp_t        e;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch && i == 4) begin
                cycles(HALF / 2);
                ps2c = 1'b0;
                cycles(3);
                ps2c = 1'b1;
                cycles(HALF / 2 - 3);
            end else begin
                cycles(HALF);
            end
            ps2c    = 1'b0;
            fall_at = cyc;
            if (want && i == nbits - 1) begin
                if (nbits == 11) begin
                    if ((par == ~^data) && stop) begin
                        e = '{is_err: 1'b0, code: data, at: fall_at + DFALL + 1};
                        last_code = data;
                    end else begin
                        e = '{is_err: 1'b1, code: last_code, at: fall_at + DFALL + 1};
                    end
                end else begin
                    e = '{is_err: 1'b1, code: last_code, at: fall_at + DFALL + TO};
                end
                exp_q.push_back(e);
            end
            cycles(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    // Monitor: every tick or error must match the oldest queued expectation
    always @(negedge clk) begin
        if (scan_done_tick || frame_err) begin
            exp_t e;
            check("tick_err_exclusive", {31'b0, scan_done_tick & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("event_was_expected", exp_q.size(), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_is_err", {31'b0, frame_err}, {31'b0, e.is_err});
                check("event_scan_code", {24'b0, scan_code}, {24'b0, e.code});
                check("event_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        cycles(5);
        reset = 1'b0;
        cycles(2);
        check("reset_scan_code", {24'b0, scan_code}, 32'h00);
        check("reset_tick", {31'b0, scan_done_tick}, 32'd0);
        check("reset_err", {31'b0, frame_err}, 32'd0);

        // 1: single good frame
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        cycles(50);
        check("t1_scan_code", {24'b0, scan_code}, 32'h1C);

        // 2: back-to-back make/break/make
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        cycles(50);
        check("t2_scan_code", {24'b0, scan_code}, 32'h1C);

        // 3: parity error keeps the old code
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b1);
        cycles(50);
        check("t3_scan_code_held", {24'b0, scan_code}, 32'h1C);

        // 4: start + 5 data bits, then the line idles into a timeout
        send_frame(8'h15, 1'b0, 1'b1, 6, 1'b0, 1'b1);
        cycles(TO + 100);
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        cycles(50);
        check("t4_scan_code", {24'b0, scan_code}, 32'h29);

        // 5: short glitches in idle and inside a frame
        ps2c = 1'b0;
        cycles(3);
        ps2c = 1'b1;
        cycles(100);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1, 1'b1);
        cycles(50);
        check("t5_scan_code", {24'b0, scan_code}, 32'h1C);

        // 6: reset mid-frame, recovery, then a frame sent with rx_en low
        send_frame(8'h1C, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        last_code = 8'h00;
        check("t6_reset_scan_code", {24'b0, scan_code}, 32'h00);
        check("t6_reset_tick", {31'b0, scan_done_tick}, 32'd0);
        check("t6_reset_err", {31'b0, frame_err}, 32'd0);
        cycles(TO + 100);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        cycles(50);
        check("t6_scan_code", {24'b0, scan_code}, 32'h1C);
        rx_en = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        cycles(100);
        rx_en = 1'b1;
        cycles(TO + 100);
        check("t6_rx_en_off_held", {24'b0, scan_code}, 32'h1C);

        check("all_expected_events_seen", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 receive front end: samples the raw keyboard clock and data lines, debounces the clock, and deserializes each 11-bit device-to-host frame (start, 8 data LSB-first, odd parity, stop). It feeds the keyboard key-tracking controller directly. It presents a validated byte on `scan_code` with a one-cycle `scan_done_tick`. Malformed or stalled frames are dropped and never produce a tick.

## Interface

Parameters:
- `FILTER_LEN`, 8: number of consecutive equal `ps2c` samples required to change the filtered clock (2..16).
- `TIMEOUT_CYCLES`, 100000: idle-edge limit within a frame before abort (1 ms at 100 MHz).

Ports:
- `clk`  input  1: system clock, all logic on rising edge.
- `reset`  input  1: synchronous, active-high; one clock with `reset`=1 returns the block to its reset state.
- `ps2c`  input  1: raw PS/2 clock line, asynchronous.
- `ps2d`  input  1: raw PS/2 data line, asynchronous.
- `rx_en`  input  1: 1 = frames may start; 0 = start bits ignored (a frame already in progress completes).
- `scan_code`  output  8: last valid received byte; held until the next valid frame.
- `scan_done_tick`  output  1: one-cycle pulse, `scan_code` updated in the same cycle.
- `frame_err`  output  1: one-cycle pulse on parity error, stop-bit error, or timeout abort.

## Operation

- Input sync: `ps2c` and `ps2d` each pass through a 2-flop synchronizer before any other use.
- Filter: synchronized `ps2c` shifts into a `FILTER_LEN`-bit register every cycle.
  - Filtered clock `fc` goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds.
  - `fc` resets to 1.
- Falling edge: `fall` = 1 for exactly one cycle when `fc` changes from 1 to 0.
- FSM states:
  - IDLE: on `fall` with synchronized `ps2d`=0 and `rx_en`=1, load the start bit, set bit counter to 10, clear the timeout counter, and go to DATA. A `fall` with `ps2d`=1 or with `rx_en`=0 is ignored.
  - DATA: on each `fall`, shift `ps2d` into the MSB of an 11-bit right-shifting register, decrement the counter, and clear the timeout counter. When the counter reaches 0 after the stop bit is shifted in, go to LOAD. With no `fall`, increment the timeout counter; on reaching `TIMEOUT_CYCLES`, pulse `frame_err` and go to IDLE.
  - LOAD: one cycle, then go to IDLE.
    - Frame register layout: [10]=stop, [9]=parity, [8:1]=data, [0]=start.
    - Good frame: XOR of [9:1] = 1 and [10] = 1. Register `scan_code` <= [8:1] and pulse `scan_done_tick`.
    - Otherwise pulse `frame_err`; `scan_code` is unchanged.
- Reset values:
  - Outputs: `scan_code`=0x00, `scan_done_tick`=0, `frame_err`=0.
  - Internal: state IDLE, counters 0, filter register all ones, synchronizers 1.
- Reset mid-frame discards the partial frame with no tick and no `frame_err`. Bits arriving after reset are accepted only from a new start bit.
- `scan_done_tick` and `frame_err` are never high in the same cycle.
- A `fall` arriving in the LOAD cycle is ignored.

## Timing

- Filter latency: `fc` falls `FILTER_LEN` + 3 cycles after a stable low on raw `ps2c` begins. This is 2 synchronizer cycles, `FILTER_LEN` samples, and 1 cycle for the register update.
- Glitches shorter than `FILTER_LEN` cycles on `ps2c` produce no `fall`.
- Data capture: `ps2d` is sampled in the `fall` cycle, through the same 2-flop delay as `ps2c`. The data line must be stable for at least `FILTER_LEN` + 3 cycles around the clock fall.
- Tick latency: `scan_done_tick` is asserted 1 cycle after the `fall` of the stop bit, which is the LOAD cycle.
- Throughput: back-to-back frames are accepted. The next start bit can be accepted one cycle after LOAD.
- Timeout: `frame_err` is asserted exactly `TIMEOUT_CYCLES` cycles after the last `fall` within DATA.

## Test plan

Use `FILTER_LEN`=8, `TIMEOUT_CYCLES`=2000, and a PS/2 clock with a 200-cycle half-period.

1. Frame 0x1C with parity 0 and stop 1 -> `scan_code`=0x1C, one `scan_done_tick` pulse 1 cycle after the stop-bit `fall`, and no `frame_err`.
2. Sequence 0x1C, 0xF0 (parity 1), 0x1C back-to-back -> three ticks in order with `scan_code` 0x1C, 0xF0, 0x1C. The downstream controller key output goes high, then low.
3. Frame 0x1C with parity 1 -> one `frame_err` pulse, no tick, and `scan_code` holds its previous value.
4. Start plus 5 data bits, then `ps2c` held high -> `frame_err` exactly 2000 cycles after the last `fall`. A following frame 0x29 (parity 0) -> `scan_code`=0x29.
5. 3-cycle low glitches on `ps2c` during IDLE and mid-frame -> no bit recorded; frame 0x1C is still received correctly.
6. `reset` pulsed after 4 bits -> no tick and no `frame_err`, outputs return to reset values. A full 0x1C frame then decodes. A frame sent with `rx_en`=0 is ignored.
